uart_tx_sched: RTL and testbench
================================

UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 Parameter: NREQ, 4, number of requesters; fixed at 4 in this revision.
REQ-002 Parameter: TIMEOUT, 4096, cycles allowed for any single wait on the transmitter before abort.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  when 0, no new arbitration; an in-flight byte still completes.
REQ-006 req  input  4  per-requester level request; bit i means requester i has a byte.
REQ-007 req_data  input  32  packed bytes; requester i's byte on bits [8i+7:8i].
REQ-008 gnt  output  4  one-hot, one-cycle pulse: requester i's byte was latched.
REQ-009 done  output  4  one-hot, one-cycle pulse: requester i's byte finished its stop bit.
REQ-010 err  output  1  one-cycle pulse on timeout abort.
REQ-011 active_id  output  2  index of the current or last granted requester.
REQ-012 sched_busy  output  1  high in any state other than IDLE.
REQ-013 uart_start  output  1  one-cycle start pulse to the UART transmitter.
REQ-014 uart_data  output  8  byte presented to the transmitter; held stable from the start pulse until the return to IDLE.
REQ-015 uart_busy  input  1  transmitter busy level.
REQ-016 uart_done  input  1  transmitter done level, held high until the next start.

Function
REQ-017 States SHALL be IDLE, LAUNCH, WAIT_BUSY and WAIT_DONE; all outputs SHALL be registered.
REQ-018 IDLE: when enable=1, req!=0 and uart_busy=0, the block SHALL pick a winner by round-robin, latch its byte and move to LAUNCH.
REQ-019 Round-robin search order SHALL begin at (last_winner+1) mod 4; last_winner is 3 after reset, so requester 0 has first priority.
REQ-020 LAUNCH (one cycle): gnt[winner]=1, uart_start=1, active_id=winner; the next state SHALL be WAIT_BUSY.
REQ-021 WAIT_BUSY: when uart_busy=1, the block SHALL move to WAIT_DONE.
REQ-022 WAIT_DONE: when uart_busy=0 and uart_done=1, the block SHALL pulse done[winner] for one cycle, set last_winner=winner, and return to IDLE.
REQ-023 Latency: from the IDLE cycle that samples req to gnt/uart_start SHALL be exactly 1 cycle.
REQ-024 A 13-bit wait counter SHALL clear on entry to WAIT_BUSY and on entry to WAIT_DONE, and SHALL increment each cycle spent in those states.
REQ-025 Timeout: if the wait counter reaches TIMEOUT-1 in WAIT_BUSY or WAIT_DONE, the block SHALL pulse err for one cycle and return to IDLE.
REQ-026 On a timeout, done SHALL NOT pulse and last_winner SHALL still advance, so a stuck requester cannot starve the others.
REQ-027 req SHALL be sampled only in IDLE; requests dropped or raised in other states are ignored until the next IDLE.
REQ-028 The block SHALL spend at least one cycle in IDLE between transactions, so back-to-back bytes are separated by one or more cycles.
REQ-029 If the granted requester still holds req on return to IDLE, it SHALL rank lowest in that arbitration.
REQ-030 If enable falls mid-transaction, the transaction SHALL complete normally; no new grant is issued while enable=0.
REQ-031 If uart_busy=1 in IDLE with req pending, the block SHALL stay in IDLE until uart_busy=0.
REQ-032 gnt, done, uart_start and err SHALL never be high for two consecutive cycles.

Reset
REQ-033 When reset_n=0, the block SHALL immediately return to IDLE regardless of clk.
REQ-034 Reset values: gnt=0, done=0, err=0, uart_start=0, uart_data=0, active_id=0, sched_busy=0, wait counter=0, last_winner=3.
REQ-035 A reset asserted mid-transaction SHALL abort it without a done or err pulse; the next grant after release SHALL follow the reset priority.

Verification
REQ-036 Scenario: reset release, then req=4'b0001 with byte 0x5A -> 1 cycle later gnt=0001, uart_start=1, uart_data=0x5A; done=0001 after the UART model finishes.
REQ-037 Scenario: req=4'b1111 held, four transactions -> grant order 0,1,2,3,0 with bytes matching req_data lanes.
REQ-038 Scenario: UART model never raises uart_busy -> err pulses TIMEOUT cycles after entering WAIT_BUSY; the next grant goes to the following requester.
REQ-039 Scenario: enable dropped during WAIT_DONE with req=1111 -> the current done pulses and no gnt follows until enable=1.
REQ-040 Scenario: reset_n pulsed low in WAIT_DONE -> outputs reach reset values immediately; after release, req=1000 is granted to requester 3 (priority restarts at 0).
REQ-041 Scenario: uart_busy=1 in IDLE with req=0010 -> no gnt until uart_busy=0, then gnt=0010 one cycle later.

Source files
------------

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin arbiter feeding single bytes to a UART transmitter,
// with a wait timeout and fair rotation after aborts.
module uart_tx_sched #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic              err,
  output logic [1:0]        active_id,
  output logic              sched_busy,
  output logic              uart_start,
  output logic [7:0]        uart_data,
  input  logic              uart_busy,
  input  logic              uart_done
);
  localparam logic [1:0] IDLE = 2'd0, LAUNCH = 2'd1, WAIT_BUSY = 2'd2, WAIT_DONE = 2'd3;
  logic [1:0]  state, last_winner, win;
  logic [12:0] wait_cnt;
  logic        timeout;
  // Scan from last_winner+NREQ down to last_winner+1 so the lowest offset wins;
  // last_winner itself (offset NREQ) ranks lowest.
  always_comb begin
    win = last_winner;
    for (int i = NREQ; i >= 1; i--)
      if (req[last_winner + 2'(i)]) win = last_winner + 2'(i);
  end
  assign timeout = wait_cnt == 13'(TIMEOUT - 1);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      last_winner <= 2'd3;
      wait_cnt    <= '0;
      gnt         <= '0;
      done        <= '0;
      err         <= 1'b0;
      uart_start  <= 1'b0;
      uart_data   <= '0;
      active_id   <= '0;
      sched_busy  <= 1'b0;
    end else begin
      gnt        <= '0;
      done       <= '0;
      err        <= 1'b0;
      uart_start <= 1'b0;
      case (state)
        IDLE:
          if (enable && |req && !uart_busy) begin
            state      <= LAUNCH;
            gnt[win]   <= 1'b1;
            uart_start <= 1'b1;
            active_id  <= win;
            uart_data  <= req_data[{win, 3'b000} +: 8];
            sched_busy <= 1'b1;
          end
        LAUNCH: begin
          state    <= WAIT_BUSY;
          wait_cnt <= '0;
        end
        WAIT_BUSY:
          if (uart_busy) begin
            state    <= WAIT_DONE;
            wait_cnt <= '0;
          end else if (timeout) begin
            state       <= IDLE;
            err         <= 1'b1;
            last_winner <= active_id;
            sched_busy  <= 1'b0;
          end else wait_cnt <= wait_cnt + 13'd1;
        default:
          if (!uart_busy && uart_done) begin
            state           <= IDLE;
            done[active_id] <= 1'b1;
            last_winner     <= active_id;
            sched_busy      <= 1'b0;
          end else if (timeout) begin
            state       <= IDLE;
            err         <= 1'b1;
            last_winner <= active_id;
            sched_busy  <= 1'b0;
          end else wait_cnt <= wait_cnt + 13'd1;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: directed scenarios for uart_tx_sched against a simple UART model.
module tb_uart_tx_sched;
  localparam int TIMEOUT = 4096;
  logic        clk = 0, reset_n = 0, enable = 1;
  logic [3:0]  req = 0;
  logic [31:0] req_data = 0;
  logic [3:0]  gnt, done;
  logic        err, sched_busy, uart_start, uart_busy, uart_done;
  logic [1:0]  active_id;
  logic [7:0]  uart_data;
  logic        model_busy = 0, ext_busy = 0, dead = 0;
  int          checks = 0, errors = 0;

  uart_tx_sched #(.NREQ(4), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .req(req), .req_data(req_data),
    .gnt(gnt), .done(done), .err(err), .active_id(active_id), .sched_busy(sched_busy),
    .uart_start(uart_start), .uart_data(uart_data), .uart_busy(uart_busy), .uart_done(uart_done)
  );

  always #5 clk = ~clk;
  assign uart_busy = model_busy | ext_busy;

  // UART model: busy one cycle after start for 3 cycles, then done held high.
  initial begin
    uart_done = 0;
    forever begin
      @(negedge clk);
      if (uart_start && !dead) begin
        uart_done = 0;
        @(negedge clk);
        model_busy = 1;
        repeat (3) @(negedge clk);
        model_busy = 0;
        uart_done = 1;
      end
    end
  end

  task automatic wait_gnt(input int bound, output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (gnt == 0 && n < bound);
  endtask

  task automatic wait_done(input int bound, output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (done == 0 && n < bound);
  endtask

  task automatic do_reset();
    reset_n = 0;
    req = 0;
    repeat (2) @(negedge clk);
    reset_n = 1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({gnt, done, err, uart_start, uart_data, active_id, sched_busy} !== '0) begin
      errors++;
      $display("FAIL reset_vals got %h want 0", {gnt, done, err, uart_start, uart_data, active_id, sched_busy});
    end
    reset_n = 1;
    @(negedge clk);
  endtask

  task automatic test_single();
    int n;
    req_data = 32'h0000_005A;
    req = 4'b0001;
    wait_gnt(20, n);
    checks++; if (n != 1) begin errors++; $display("FAIL single_latency got %0d want 1", n); end
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL single_gnt got %b want 0001", gnt); end
    checks++; if (uart_start !== 1'b1) begin errors++; $display("FAIL single_start got %b want 1", uart_start); end
    checks++; if (uart_data !== 8'h5A) begin errors++; $display("FAIL single_data got %h want 5a", uart_data); end
    checks++; if (sched_busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b want 1", sched_busy); end
    req = 0;
    @(negedge clk);
    checks++; if ({gnt, uart_start} !== 5'b0) begin errors++; $display("FAIL single_pulse got %b want 0", {gnt, uart_start}); end
    wait_done(50, n);
    checks++; if (done !== 4'b0001) begin errors++; $display("FAIL single_done got %b want 0001", done); end
    @(negedge clk);
    checks++; if (done !== 4'b0000) begin errors++; $display("FAIL single_done_pulse got %b want 0000", done); end
  endtask

  task automatic test_round_robin();
    int n;
    int order [5] = '{0, 1, 2, 3, 0};
    logic [7:0] lane [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_reset();
    req_data = 32'h4433_2211;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_gnt(20, n);
      checks++; if (n != 1) begin errors++; $display("FAIL rr_gap%0d got %0d want 1", k, n); end
      checks++; if (gnt !== 4'(1 << order[k])) begin errors++; $display("FAIL rr_gnt%0d got %b want %b", k, gnt, 4'(1 << order[k])); end
      checks++; if (uart_data !== lane[order[k]]) begin errors++; $display("FAIL rr_data%0d got %h want %h", k, uart_data, lane[order[k]]); end
      if (k == 4) req = 0;
      wait_done(50, n);
      checks++; if (done !== 4'(1 << order[k])) begin errors++; $display("FAIL rr_done%0d got %b want %b", k, done, 4'(1 << order[k])); end
    end
  endtask

  task automatic test_timeout();
    int n;
    dead = 1;
    req = 4'b1111;
    wait_gnt(20, n);
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL to_gnt got %b want 0010", gnt); end
    n = 0;
    do begin @(negedge clk); n++; end while (!err && n < TIMEOUT + 20);
    checks++; if (n != TIMEOUT + 1) begin errors++; $display("FAIL to_delay got %0d want %0d", n, TIMEOUT + 1); end
    checks++; if ({err, done} !== 5'b10000) begin errors++; $display("FAIL to_err_done got %b want 10000", {err, done}); end
    dead = 0;
    wait_gnt(20, n);
    checks++; if (n != 1 || gnt !== 4'b0100) begin errors++; $display("FAIL to_next got gnt %b after %0d want 0100 after 1", gnt, n); end
    req = 0;
    wait_done(50, n);
    checks++; if (done !== 4'b0100) begin errors++; $display("FAIL to_done got %b want 0100", done); end
  endtask

  task automatic test_enable();
    int n, seen;
    req = 4'b1111;
    wait_gnt(20, n);
    checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL en_gnt got %b want 1000", gnt); end
    repeat (2) @(negedge clk);
    enable = 0;
    wait_done(50, n);
    checks++; if (done !== 4'b1000) begin errors++; $display("FAIL en_done got %b want 1000", done); end
    seen = 0;
    repeat (10) begin @(negedge clk); if (gnt != 0) seen++; end
    checks++; if (seen != 0) begin errors++; $display("FAIL en_hold got %0d grants want 0", seen); end
    enable = 1;
    wait_gnt(20, n);
    checks++; if (n != 1 || gnt !== 4'b0001) begin errors++; $display("FAIL en_resume got gnt %b after %0d want 0001 after 1", gnt, n); end
    req = 0;
    wait_done(50, n);
  endtask

  task automatic test_reset_mid();
    int n, seen;
    req = 4'b1111;
    wait_gnt(20, n);
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL rm_gnt got %b want 0010", gnt); end
    repeat (3) @(negedge clk);
    reset_n = 0;
    #1;
    checks++;
    if ({gnt, done, err, uart_start, uart_data, active_id, sched_busy} !== '0) begin
      errors++;
      $display("FAIL rm_async got %h want 0", {gnt, done, err, uart_start, uart_data, active_id, sched_busy});
    end
    req = 4'b1000;
    @(negedge clk);
    reset_n = 1;
    n = 0;
    seen = 0;
    do begin @(negedge clk); n++; if (done != 0 || err) seen++; end while (gnt == 0 && n < 50);
    checks++; if (seen != 0) begin errors++; $display("FAIL rm_no_pulse got %0d want 0", seen); end
    checks++; if (gnt !== 4'b1000 || active_id !== 2'd3) begin errors++; $display("FAIL rm_regrant got %b id %0d want 1000 id 3", gnt, active_id); end
    req = 0;
    wait_done(50, n);
  endtask

  task automatic test_busy_idle();
    int n, seen;
    @(negedge clk);
    ext_busy = 1;
    req = 4'b0010;
    seen = 0;
    repeat (6) begin @(negedge clk); if (gnt != 0) seen++; end
    checks++; if (seen != 0) begin errors++; $display("FAIL bi_hold got %0d grants want 0", seen); end
    ext_busy = 0;
    wait_gnt(20, n);
    checks++; if (n != 1 || gnt !== 4'b0010) begin errors++; $display("FAIL bi_gnt got %b after %0d want 0010 after 1", gnt, n); end
    req = 0;
    wait_done(50, n);
    checks++; if (done !== 4'b0010) begin errors++; $display("FAIL bi_done got %b want 0010", done); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_enable();
    test_reset_mid();
    test_busy_idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
